div_seq_ctrl: RTL and testbench

// - Iterative restoring divider with an FSM controller; unsigned n/d -> quotient q, remainder r.
// - Produces one quotient bit per clock, MSB first, over WIDTH cycles.
// - Uses a start/ready/done handshake, so one small subtractor replaces the combinational array divider.
// - Sits between a requesting unit (ALU/test harness) and the result consumer.

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_step.sv | 34 +++
 rtl/div_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_div_seq_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_t            controller states (IDLE, RUN, FIN)
//   DIV_WIDTH_DEFAULT  default operand width
//   cnt_w()            width of the step counter for a given operand width
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int DIV_WIDTH_DEFAULT = 8;

  // The step counter runs 0..width-1; $clog2 of 2 is 1, which still covers it.
  function automatic int cnt_w(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step (purely combinational).
//   i_rem  partial remainder before the step
//   i_quo  dividend/quotient shift register before the step
//   i_den  divisor
//   o_rem  partial remainder after shift and conditional subtract
//   o_quo  shift register after shift, new quotient bit in bit 0
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_den,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH-1:0] w_rem_sh;
  logic [WIDTH:0]   w_trial;

  // {rem,quo} shifted left by one: the dividend MSB moves into the remainder.
  assign w_rem_sh = {i_rem[WIDTH-2:0], i_quo[WIDTH-1]};

  // The bit shifted out of rem is always 0 (rem < den before each shift and
  // rem < 2^(step-1)), so using it as the trial's top bit keeps full
  // precision without changing the result.
  assign w_trial = {i_rem[WIDTH-1], w_rem_sh} - {1'b0, i_den};

  // Trial MSB clear means the subtraction fit: keep it and emit a 1.
  assign o_rem = w_trial[WIDTH] ? w_rem_sh : w_trial[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], ~w_trial[WIDTH]};

endmodule

// File: rtl/div_seq_ctrl.sv
// Iterative restoring divider: unsigned n/d -> q, r, one quotient bit per
// clock, MSB first, over WIDTH RUN cycles, behind a start/ready/done handshake.
//   clk, rst      clock; asynchronous active-high reset
//   start, n, d   request and operands, sampled only while ready=1
//   ready         state is IDLE
//   busy          state is RUN
//   done          one-cycle pulse in FIN; q/r/div_by_zero valid from here
//   q, r          registered quotient/remainder, held until next result
//   div_by_zero   registered flag for the last result, held with q/r
module div_seq_ctrl
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] n,
  input  logic [WIDTH-1:0] d,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  localparam int             CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_den;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_dbz;

  logic [WIDTH-1:0] w_step_rem;
  logic [WIDTH-1:0] w_step_quo;
  logic             w_accept;
  logic             w_div0;
  logic             w_last;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_den (r_den),
    .o_rem (w_step_rem),
    .o_quo (w_step_quo)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_div0      = 1'b0;
    w_last      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          // A zero divisor skips RUN and reports the fixed result directly.
          if (d == '0) begin
            w_div0      = 1'b1;
            w_state_nxt = FIN;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (r_cnt == CNT_LAST) begin
          w_last      = 1'b1;
          w_state_nxt = FIN;
        end
      end
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem <= '0;
      r_quo <= '0;
      r_den <= '0;
      r_cnt <= '0;
      r_q   <= '0;
      r_r   <= '0;
      r_dbz <= 1'b0;
    end else begin
      if (w_accept) begin
        r_rem <= '0;
        r_quo <= n;
        r_den <= d;
        r_cnt <= '0;
      end else if (r_state == RUN) begin
        r_rem <= w_step_rem;
        r_quo <= w_step_quo;
        r_cnt <= r_cnt + 1'b1;
      end

      // Results change only here, so they hold steady through IDLE.
      if (w_div0) begin
        r_q   <= '1;
        r_r   <= n;
        r_dbz <= 1'b1;
      end else if (w_last) begin
        r_q   <= w_step_quo;
        r_r   <= w_step_rem;
        r_dbz <= 1'b0;
      end
    end
  end

  assign ready       = (r_state == IDLE);
  assign busy        = (r_state == RUN);
  assign done        = (r_state == FIN);
  assign q           = r_q;
  assign r           = r_r;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl (WIDTH=8): directed cases, handshake
// and reset scenarios, then randomized operands against an arithmetic model.
module tb_div_seq_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] n;
  logic [W-1:0] d;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         dbz;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  div_seq_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .n           (n),
    .d           (d),
    .ready       (ready),
    .busy        (busy),
    .done        (done),
    .q           (q),
    .r           (r),
    .div_by_zero (dbz)
  );

  task automatic check_eq(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: tracks by edge number when the current operation was
  // accepted, on which edge its result lands, and the arithmetic result.
  int           ec = 0;
  bit           m_active = 1'b0;
  int           m_done_edge = 0;
  logic [W-1:0] m_q_pend = '0, m_r_pend = '0;
  logic [W-1:0] m_q = '0, m_r = '0;
  bit           m_dz = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 1'b0;
      m_q      = '0;
      m_r      = '0;
      m_dz     = 1'b0;
    end else begin
      ec++;
      if (!m_active) begin
        if (start) begin
          m_active = 1'b1;
          if (d == 0) begin
            m_done_edge = ec;
            m_q  = '1;
            m_r  = n;
            m_dz = 1'b1;
          end else begin
            m_done_edge = ec + W;
            m_q_pend = n / d;
            m_r_pend = n % d;
          end
        end
      end else if (ec == m_done_edge) begin
        m_q  = m_q_pend;
        m_r  = m_r_pend;
        m_dz = 1'b0;
      end else if (ec == m_done_edge + 1) begin
        m_active = 1'b0;
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    bit e_ready, e_busy, e_done;
    e_ready = !m_active;
    e_done  = m_active && (ec == m_done_edge);
    e_busy  = m_active && !e_done;
    check_eq("one_hot", int'(ready) + int'(busy) + int'(done), 1);
    check_eq("ctrl_rbd", {ready, busy, done}, {e_ready, e_busy, e_done});
    check_eq("result_qrz", {q, r, dbz}, {m_q, m_r, m_dz});
  end

  // Waits for ready, issues one op for a single cycle, waits for done.
  // Returns at the negedge where done is high; busy_cnt counts busy cycles.
  task automatic run_op(input logic [W-1:0] an, input logic [W-1:0] ad, output int busy_cnt);
    int waited = 0;
    @(negedge clk);
    while (!ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    start = 1'b1;
    n     = an;
    d     = ad;
    @(negedge clk);
    start = 1'b0;
    check_eq("ready_drop", ready, 0);
    busy_cnt = 0;
    waited   = 0;
    while (!done && waited < 40) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      waited++;
    end
    check_eq("done_seen", done, 1);
  endtask

  initial begin
    int bc;
    int waited;
    int dcnt;
    logic [W-1:0] tn [4] = '{8'd12, 8'd255, 8'd255, 8'd0};
    logic [W-1:0] td [4] = '{8'd13, 8'd1,   8'd255, 8'd9};
    logic [W-1:0] tq [4] = '{8'd0,  8'd255, 8'd1,   8'd0};
    logic [W-1:0] tr [4] = '{8'd12, 8'd0,   8'd0,   8'd0};

    rst = 1'b1; start = 1'b0; n = '0; d = '0;
    #3;
    check_eq("reset_ctrl", {ready, busy, done}, 3'b100);
    check_eq("reset_qrz", {q, r, dbz}, 17'd0);
    @(negedge clk); @(negedge clk);
    #2 rst = 1'b0;

    // 100/30: latency, busy length and literal result; also pins the model.
    run_op(8'd100, 8'd30, bc);
    check_eq("b100_busy_cycles", bc, W);
    check_eq("b100_q", q, 3);
    check_eq("b100_r", r, 10);
    check_eq("b100_dz", dbz, 0);
    check_eq("model_pin_q", m_q, 3);
    check_eq("model_pin_r", m_r, 10);

    for (int i = 0; i < 4; i++) begin
      run_op(tn[i], td[i], bc);
      check_eq("edge_q", q, tq[i]);
      check_eq("edge_r", r, tr[i]);
      check_eq("edge_dz", dbz, 0);
    end

    // Divide by zero: no RUN cycles, done right after the accepting edge.
    run_op(8'd77, 8'd0, bc);
    check_eq("dz_busy_cycles", bc, 0);
    check_eq("dz_qrz", {q, r, dbz}, {8'd255, 8'd77, 1'b1});
    check_eq("model_pin_dz", {m_q, m_r, m_dz}, {8'd255, 8'd77, 1'b1});

    // Back-to-back: start held high with changing operands during RUN.
    @(negedge clk);
    waited = 0;
    while (!ready && waited < 100) begin @(negedge clk); waited++; end
    start = 1'b1; n = 8'd200; d = 8'd7;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
      if (!done) begin
        n = W'($urandom);
        d = W'($urandom_range(1, 255));
      end
    end while (!done && waited < 40);
    check_eq("b2b_done_seen", done, 1);
    check_eq("b2b_first_q", q, 28);
    check_eq("b2b_first_r", r, 4);
    n = 8'd50; d = 8'd5;
    @(negedge clk);
    check_eq("b2b_ready_after_fin", ready, 1);
    @(negedge clk);
    start = 1'b0;
    check_eq("b2b_second_busy", busy, 1);
    waited = 0;
    while (!done && waited < 40) begin @(negedge clk); waited++; end
    check_eq("b2b_second_qr", {q, r}, {8'd10, 8'd0});

    // Reset in the fourth RUN cycle of 100/30: abort, no done afterwards.
    @(negedge clk);
    waited = 0;
    while (!ready && waited < 100) begin @(negedge clk); waited++; end
    start = 1'b1; n = 8'd100; d = 8'd30;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("abort_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("abort_qrz", {q, r, dbz}, 17'd0);
    check_eq("abort_ctrl", {ready, busy, done}, 3'b100);
    @(negedge clk);
    #2 rst = 1'b0;
    dcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check_eq("abort_no_done", dcnt, 0);

    // Randomized operands, including zero and small divisors.
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] an, ad, eq, er;
      bit ez;
      an = W'($urandom_range(0, 255));
      if (i % 16 == 0)      ad = '0;
      else if (i % 3 == 0)  ad = W'($urandom_range(1, 15));
      else                  ad = W'($urandom_range(1, 255));
      run_op(an, ad, bc);
      if (ad == 0) begin eq = '1; er = an; ez = 1'b1; end
      else begin eq = an / ad; er = an % ad; ez = 1'b0; end
      check_eq("rand_qrz", {q, r, dbz}, {eq, er, ez});
      check_eq("rand_busy_cycles", bc, (ad == 0) ? 0 : W);
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
